// File: rtl/and_gate_dual_style_pkg.sv
// Shared constants for gate-library observers so every instance agrees on counter width.
package and_gate_dual_style_pkg;

    localparam int unsigned CNT_W_DEFAULT = 16;
    localparam logic [CNT_W_DEFAULT-1:0] CNT_MAX = '1;

endpackage

// File: rtl/and_gate_dual_style.sv
// Two-input AND driven by two independent combinational constructs, plus a clocked observer
// (registered copy and saturating high-cycle count) that never feeds back into the gate.
module and_gate_dual_style
    import and_gate_dual_style_pkg::*;
#(
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    output logic             out_assign,
    output logic             out_alwaysblock,
    output logic             out_q,
    output logic [CNT_W-1:0] high_cnt
);

    localparam logic [CNT_W-1:0] CntSat = '1;

    logic             r_out_q;
    logic [CNT_W-1:0] r_high_cnt;
    logic             w_and;

    // The two outputs are deliberately separate constructs; neither is derived from the other.
    assign out_assign = a & b;

    always_comb begin
        out_alwaysblock = a & b;
    end

    assign w_and = a & b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_q    <= 1'b0;
            r_high_cnt <= '0;
        end else begin
            r_out_q <= w_and;
            if (w_and && (r_high_cnt != CntSat)) begin
                r_high_cnt <= r_high_cnt + CNT_W'(1);
            end
        end
    end

    assign out_q    = r_out_q;
    assign high_cnt = r_high_cnt;

endmodule

// File: tb/tb_and_gate_dual_style.sv
// Randomized and directed checks of the dual-style AND gate against a behavioural model.
module tb_and_gate_dual_style;

    logic        clk;
    logic        rst_n;
    logic        a;
    logic        b;
    logic        out_assign;
    logic        out_alwaysblock;
    logic        out_q;
    logic [15:0] high_cnt;
    logic        out_assign3;
    logic        out_alwaysblock3;
    logic        out_q3;
    logic [2:0]  high_cnt3;

    int n_chk = 0;
    int n_err = 0;
    bit en    = 1'b0;

    // Behavioural model state
    logic exp_q;
    int   exp_cnt;
    int   exp_cnt3;

    and_gate_dual_style dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .a               (a),
        .b               (b),
        .out_assign      (out_assign),
        .out_alwaysblock (out_alwaysblock),
        .out_q           (out_q),
        .high_cnt        (high_cnt)
    );

    and_gate_dual_style #(.CNT_W(3)) dut3 (
        .clk             (clk),
        .rst_n           (rst_n),
        .a               (a),
        .b               (b),
        .out_assign      (out_assign3),
        .out_alwaysblock (out_alwaysblock3),
        .out_q           (out_q3),
        .high_cnt        (high_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: counts qualifying rising edges, saturating at the counter's maximum.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q    = 1'b0;
            exp_cnt  = 0;
            exp_cnt3 = 0;
        end else begin
            exp_q = a & b;
            if ((a & b) === 1'b1) begin
                if (exp_cnt < 65535) exp_cnt = exp_cnt + 1;
                if (exp_cnt3 < 7)    exp_cnt3 = exp_cnt3 + 1;
            end
        end
    end

    // Compare on both clock edges, 1 time unit after the edge.
    always @(clk) begin
        #1;
        if (en) begin
            chk("out_assign",       32'(out_assign),       32'(a & b));
            chk("out_alwaysblock",  32'(out_alwaysblock),  32'(a & b));
            chk("out_assign3",      32'(out_assign3),      32'(a & b));
            chk("out_alwaysblock3", 32'(out_alwaysblock3), 32'(a & b));
            chk("out_q",            32'(out_q),            32'(exp_q));
            chk("out_q3",           32'(out_q3),           32'(exp_q));
            chk("high_cnt",         32'(high_cnt),         32'(exp_cnt));
            chk("high_cnt3",        32'(high_cnt3),        32'(exp_cnt3));
        end
    end

    task automatic at_pos();
        @(posedge clk);
        #2;
    endtask

    task automatic at_neg();
        @(negedge clk);
        #2;
    endtask

    task automatic do_reset();
        at_neg();
        rst_n = 1'b0;
        at_neg();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [1:0] tt;
        rst_n = 1'b0;
        a     = 1'b0;
        b     = 1'b0;
        repeat (2) at_neg();
        chk("reset_out_q",    32'(out_q),    32'd0);
        chk("reset_high_cnt", 32'(high_cnt), 32'd0);
        en = 1'b1;

        // Hold 1,1 after reset: out_q from first edge, counts 5 then saturate CNT_W=3 at 7.
        at_neg();
        rst_n = 1'b1;
        a     = 1'b1;
        b     = 1'b1;
        @(posedge clk);
        #1;
        chk("hold_q_first_edge", 32'(out_q),    32'd1);
        chk("hold_cnt_first",    32'(high_cnt), 32'd1);
        repeat (4) @(posedge clk);
        #1;
        chk("hold_cnt5",  32'(high_cnt),  32'd5);
        chk("hold_cnt3a", 32'(high_cnt3), 32'd5);
        repeat (5) @(posedge clk);
        #1;
        chk("hold_cnt10", 32'(high_cnt),  32'd10);
        chk("sat_cnt3",   32'(high_cnt3), 32'd7);

        // Truth-table sweep, one combination per edge.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            tt = 2'(i);
            at_pos();
            a = tt[1];
            b = tt[0];
            #1;
            chk("tt_assign", 32'(out_assign),      (i == 3) ? 32'd1 : 32'd0);
            chk("tt_always", 32'(out_alwaysblock), (i == 3) ? 32'd1 : 32'd0);
        end

        // Mid-cycle reset with count at 4.
        do_reset();
        a = 1'b1;
        b = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        chk("pre_rst_cnt4", 32'(high_cnt), 32'd4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_cnt",    32'(high_cnt),   32'd0);
        chk("mid_rst_q",      32'(out_q),      32'd0);
        chk("mid_rst_assign", 32'(out_assign), 32'd1);
        b = 1'b0;
        #1;
        chk("mid_rst_assign0", 32'(out_assign),      32'd0);
        chk("mid_rst_always0", 32'(out_alwaysblock), 32'd0);
        at_neg();
        rst_n = 1'b1;
        b     = 1'b1;

        // Two counted cycles, then a=1,b=0 for 4 cycles: count frozen.
        repeat (2) @(posedge clk);
        #1;
        chk("resume_cnt2", 32'(high_cnt), 32'd2);
        #1;
        b = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("a1b0_cnt", 32'(high_cnt), 32'd2);
        chk("a1b0_q",   32'(out_q),    32'd0);
        chk("a1b0_out", 32'(out_assign | out_alwaysblock), 32'd0);

        // 400 random changes on both edges.
        for (int i = 0; i < 200; i++) begin
            at_pos();
            a = 1'($urandom);
            b = 1'($urandom);
            if ($urandom_range(0, 49) == 0) rst_n = 1'b0;
            at_neg();
            a     = 1'($urandom);
            b     = 1'($urandom);
            rst_n = 1'b1;
        end

        // Unknown-input propagation on the combinational paths only.
        at_neg();
        en = 1'b0;
        a  = 1'b0;
        b  = 1'bx;
        #1;
        chk("x_zero_assign", 32'(out_assign),      32'd0);
        chk("x_zero_always", 32'(out_alwaysblock), 32'd0);
        a = 1'b1;
        #1;
        chk("x_one_assign", 32'(out_assign),      32'(1'bx));
        chk("x_one_always", 32'(out_alwaysblock), 32'(1'bx));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
